// File: rtl/lfsr_rand_delay.sv
// lfsr_rand_delay: Fibonacci LFSR feeding a tick-prescaled random delay timer.
// A start in IDLE draws D = MIN_DLY + low LFSR bits (clamped to MAX_DLY),
// counts D ticks of TICK_DIV clocks each, then holds ready until ack.
module lfsr_rand_delay #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   TAPS     = 16'hB400,
    parameter int                 MIN_DLY  = 500,
    parameter int                 MAX_DLY  = 5000,
    parameter int                 TICK_DIV = 50000,
    localparam int                RW       = $clog2(MAX_DLY - MIN_DLY + 1),
    localparam int                CW       = $clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    output logic [WIDTH-1:0] rnd,
    output logic [CW-1:0]    delay_val,
    output logic             busy,
    output logic             ready
);

    // A zero-width random field (MIN_DLY == MAX_DLY) still needs one bit to
    // slice; the clamp then pins the result to MAX_DLY anyway.
    localparam int RWS = (RW < 1) ? 1 : RW;
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [CW:0]   MIN_EXT    = (CW + 1)'(MIN_DLY);
    localparam logic [CW:0]   MAX_EXT    = (CW + 1)'(MAX_DLY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    prescale;
    logic [CW-1:0]    tick_cnt;

    logic             fb;
    logic [WIDTH-1:0] rnd_next;
    logic [RWS-1:0]   raw;
    logic [CW:0]      dly_sum;
    logic [CW-1:0]    dly_clamped;

    // Next LFSR state and the candidate delay drawn from the current state.
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment); a missed path would infer a latch.
    always_comb begin
        fb          = ^(rnd & TAPS);
        rnd_next    = {rnd[WIDTH-2:0], fb};
        raw         = rnd[RWS-1:0];
        // One extra bit of headroom so MIN_DLY + raw cannot wrap before the clamp.
        dly_sum     = MIN_EXT + (CW + 1)'(raw);
        dly_clamped = (dly_sum > MAX_EXT) ? MAX_EXT[CW-1:0] : dly_sum[CW-1:0];
    end

    // LFSR register: seeds on request (zero seed mapped to 1), free-runs otherwise.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd <= WIDTH'(1);
        end else if (seed_load) begin
            rnd <= (seed == '0) ? WIDTH'(1) : seed;
        end else begin
            rnd <= rnd_next;
        end
    end

    // Delay FSM with registered busy/ready; abort outranks terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ready     <= 1'b0;
            delay_val <= '0;
            prescale  <= '0;
            tick_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        delay_val <= dly_clamped;
                        tick_cnt  <= dly_clamped;
                        prescale  <= PRE_RELOAD;
                        state     <= COUNT;
                        busy      <= 1'b1;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (prescale == '0) begin
                        prescale <= PRE_RELOAD;
                        tick_cnt <= tick_cnt - CW'(1);
                        if (tick_cnt == CW'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end
                    end else begin
                        prescale <= prescale - PW'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_delay.sv
// tb_lfsr_rand_delay: directed bench for lfsr_rand_delay with a ready scoreboard.
// Stimulus pushes the expected delay_val and ready cycle for every start that
// should complete; the monitor pops and compares on each rising ready.
module tb_lfsr_rand_delay;

    localparam int         WIDTH    = 8;
    localparam logic [7:0] TAPS     = 8'hB8;
    localparam int         MIN_DLY  = 4;
    localparam int         MAX_DLY  = 10;
    localparam int         TICK_DIV = 3;
    localparam int         CW       = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             start;
    logic             abort;
    logic             ack;
    logic [WIDTH-1:0] rnd;
    logic [CW-1:0]    delay_val;
    logic             busy;
    logic             ready;

    lfsr_rand_delay #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .MIN_DLY  (MIN_DLY),
        .MAX_DLY  (MAX_DLY),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .start     (start),
        .abort     (abort),
        .ack       (ack),
        .rnd       (rnd),
        .delay_val (delay_val),
        .busy      (busy),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned dly;
        int unsigned at_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   ready_rises = 0;
    logic ready_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard monitor: every rising ready must match the oldest expectation.
    always @(negedge clk) begin
        if (ready && !ready_q) begin
            ready_rises <= ready_rises + 1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: ready rose at cycle %0d, no completion expected", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_delay_val", 32'(delay_val), mon_e.dly);
                check("done_cycle", cyc, mon_e.at_cyc);
            end
        end
        ready_q <= ready;
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_seed(input logic [WIDTH-1:0] s);
        seed      = s;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
    endtask

    // Drives start for one edge; optionally records the expected completion.
    task automatic issue_start(input int dly, input bit expect_done);
        start = 1'b1;
        if (expect_done)
            exp_q.push_back('{dly: dly, at_cyc: cyc + 1 + dly * TICK_DIV});
        step();
        start = 1'b0;
    endtask

    task automatic wait_ready(input int bound);
        for (int i = 0; i < bound && !ready; i++) step();
        check("ready_wait", 32'(ready), 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ack_ready_clear", 32'(ready), 0);
        check("ack_busy_clear", 32'(busy), 0);
    endtask

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [7:0] exp_seq [8];
    bit         seen [256];
    int         distinct;
    int         ret_at;
    int         zero_cnt;
    int         busy_cnt;
    int         rises_before;

    initial begin
        // Reset with every other control asserted: reset must win.
        reset     = 1'b1;
        seed_load = 1'b1;
        seed      = 8'h55;
        start     = 1'b1;
        abort     = 1'b1;
        ack       = 1'b1;
        step(3);
        check("reset_rnd", 32'(rnd), 32'h01);
        check("reset_busy", 32'(busy), 0);
        check("reset_ready", 32'(ready), 0);
        check("reset_delay_val", 32'(delay_val), 0);
        reset     = 1'b0;
        seed_load = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ack       = 1'b0;
        step();
        check("first_advance", 32'(rnd), 32'h02);
        check("idle_busy", 32'(busy), 0);

        // Hand-stepped Fibonacci sequence from seed 0x01.
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        load_seed(8'h01);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lfsr_seq_%0d", i), 32'(rnd), 32'(exp_seq[i]));
            step();
        end

        // Full period from 0x01: back to 0x01 at exactly 255, never 0, 255 distinct.
        load_seed(8'h01);
        foreach (seen[i]) seen[i] = 1'b0;
        seen[rnd] = 1'b1;
        distinct  = 1;
        ret_at    = 0;
        zero_cnt  = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (rnd == 8'h00) zero_cnt++;
            if (rnd == 8'h01 && ret_at == 0) ret_at = i;
            if (i < 255 && !seen[rnd]) begin
                seen[rnd] = 1'b1;
                distinct++;
            end
        end
        check("period_return", 32'(ret_at), 255);
        check("period_no_zero", 32'(zero_cnt), 0);
        check("period_distinct", 32'(distinct), 255);

        // Zero seed maps to 0x01.
        load_seed(8'h00);
        check("seed_zero", 32'(rnd), 32'h01);

        // raw 1 -> D = 5: 15 busy cycles, ready held until ack.
        load_seed(8'h01);
        issue_start(5, 1'b1);
        check("d5_delay_val", 32'(delay_val), 5);
        check("d5_busy_rise", 32'(busy), 1);
        check("d5_ready_low", 32'(ready), 0);
        busy_cnt = 0;
        while (busy && busy_cnt < 100) begin
            busy_cnt++;
            step();
        end
        check("d5_busy_cycles", 32'(busy_cnt), 15);
        check("d5_ready_rise", 32'(ready), 1);
        step(3);
        check("d5_ready_held", 32'(ready), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_done", 32'(ready), 1);
        // start alongside ack in DONE is ignored.
        ack   = 1'b1;
        start = 1'b1;
        step();
        ack   = 1'b0;
        start = 1'b0;
        check("ack_start_ready", 32'(ready), 0);
        check("ack_start_busy", 32'(busy), 0);
        step(2);
        check("ack_start_no_count", 32'(busy), 0);
        check("ack_start_delay_hold", 32'(delay_val), 5);

        // raw 7 -> 11, clamped to 10; ready 30 cycles after start.
        load_seed(8'h07);
        issue_start(10, 1'b1);
        check("d10_delay_val", 32'(delay_val), 10);
        wait_ready(100);
        do_ack();

        // Start in COUNT ignored; abort on the terminal-count cycle wins.
        load_seed(8'h01);
        issue_start(5, 1'b0);
        step(4);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_count_busy", 32'(busy), 1);
        check("start_in_count_delay", 32'(delay_val), 5);
        step(9);
        check("pre_terminal_busy", 32'(busy), 1);
        check("pre_terminal_ready", 32'(ready), 0);
        rises_before = ready_rises;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(ready), 0);
        step(40);
        check("abort_no_ready", 32'(ready_rises - rises_before), 0);

        // Reset mid-COUNT.
        load_seed(8'h01);
        issue_start(5, 1'b0);
        step(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_rnd", 32'(rnd), 32'h01);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_ready", 32'(ready), 0);
        check("midreset_delay_val", 32'(delay_val), 0);
        rises_before = ready_rises;
        step(30);
        check("midreset_no_ready", 32'(ready_rises - rises_before), 0);

        // seed_load with start: delay uses the pre-load rnd (0x01 -> 5).
        load_seed(8'h01);
        seed      = 8'h07;
        seed_load = 1'b1;
        issue_start(5, 1'b1);
        seed_load = 1'b0;
        check("load_start_rnd", 32'(rnd), 32'h07);
        check("load_start_delay", 32'(delay_val), 5);
        wait_ready(100);
        do_ack();

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check("pending_expectations", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_delay.md
LFSR_RAND_DELAY -- requirements
Module: lfsr_rand_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 16: LFSR width in bits, legal range 3..32.
REQ-002 SHALL have parameter TAPS, default 16'hB400: feedback tap mask (bit i set = state bit i feeds the XOR); bit WIDTH-1 SHALL be set.
REQ-003 SHALL have parameter MIN_DLY, default 500: minimum delay in ticks; legal value is 1 or more.
REQ-004 SHALL have parameter MAX_DLY, default 5000: maximum delay in ticks; legal value is MIN_DLY or more.
REQ-005 SHALL have parameter TICK_DIV, default 50000: clk cycles per tick; legal value is 1 or more.
REQ-006 SHALL define derived widths: RW = clog2(MAX_DLY-MIN_DLY+1), with RW <= WIDTH; CW = clog2(MAX_DLY+1).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port seed_load, input, 1 bit: load seed into the LFSR.
REQ-010 SHALL have port seed, input, WIDTH bits: seed value.
REQ-011 SHALL have port start, input, 1 bit: request a random delay.
REQ-012 SHALL have port abort, input, 1 bit: cancel the delay in progress.
REQ-013 SHALL have port ack, input, 1 bit: consume ready.
REQ-014 SHALL have port rnd, output, WIDTH bits: current LFSR state.
REQ-015 SHALL have port delay_val, output, CW bits: captured delay in ticks.
REQ-016 SHALL have port busy, output, 1 bit: delay counting.
REQ-017 SHALL have port ready, output, 1 bit: delay expired, held until ack.

Function
REQ-018 LFSR SHALL be Fibonacci form: fb = XOR of rnd[i] for every i with TAPS[i]=1; next = {rnd[WIDTH-2:0], fb}.
REQ-019 LFSR SHALL advance every cycle when not in reset and not loading.
REQ-020 On seed_load, rnd SHALL take seed the next cycle; if seed is 0, rnd SHALL take 1 (no lockout state).
REQ-021 rnd SHALL never equal 0.
REQ-022 FSM SHALL have states IDLE, COUNT and DONE; busy = (state==COUNT) and ready = (state==DONE), both registered.
REQ-023 In IDLE, when start=1: D = MIN_DLY + rnd[RW-1:0], clamped to MAX_DLY if larger; D SHALL be captured into delay_val and the tick counter; the prescaler SHALL load TICK_DIV-1; next state is COUNT.
REQ-024 In COUNT, when the prescaler is 0: reload TICK_DIV-1 and decrement the tick counter; when the tick counter is 1, next state is DONE. Otherwise the prescaler decrements.
REQ-025 Latency: with start sampled at edge k, busy SHALL rise after edge k and ready SHALL rise after edge k + D*TICK_DIV.
REQ-026 In DONE, ack=1 SHALL cause next state IDLE; ready SHALL stay asserted until then.
REQ-027 abort=1 in COUNT SHALL cause next state IDLE and SHALL have priority over terminal count in the same cycle.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 start outside IDLE SHALL be ignored, including start together with ack in DONE; a new start is needed in IDLE.
REQ-030 When seed_load and start occur in the same cycle, D SHALL use the pre-load rnd value.
REQ-031 delay_val SHALL hold its value until the next accepted start.
REQ-032 No arithmetic SHALL overflow: the MIN_DLY+raw sum SHALL be computed at CW+1 bits before the clamp.

Reset
REQ-033 When reset=1 at a clock edge: rnd=1, state=IDLE, busy=0, ready=0, delay_val=0, prescaler=0, tick counter=0.
REQ-034 reset SHALL override seed_load, start, abort and ack.
REQ-035 reset during COUNT or DONE SHALL return to IDLE with no ready pulse.

Verification (bench params: WIDTH=8, TAPS=8'hB8, MIN_DLY=4, MAX_DLY=10, TICK_DIV=3; RW=3, CW=4)
REQ-036 Seed 0x01, free-run: rnd SHALL return to 0x01 after exactly 255 cycles, never be 0x00, and visit 255 distinct values.
REQ-037 seed_load with seed=0x00: rnd SHALL read 0x01 the next cycle.
REQ-038 Load 0x01, start next cycle: delay_val=5, busy for 15 cycles, then ready=1 held until ack, then IDLE.
REQ-039 Load 0x07, start next cycle: raw 7 gives 11, clamped so delay_val=10, and ready SHALL rise 30 cycles after start.
REQ-040 Abort on the exact terminal-count cycle: the FSM SHALL enter IDLE and ready SHALL never assert; a start during COUNT SHALL be ignored, with delay_val unchanged.
REQ-041 Reset mid-COUNT: all outputs SHALL take reset values next cycle, and rnd=0x01.
